// File: rtl/ysyx_pipe_pkg.sv
// ysyx_pipe_pkg: shared definitions for the five-stage valid/ready chain.
//   - Payload widths for each inter-stage buffer (IFU->IDU, IDU->EXU, EXU->LSU, LSU->WBU).
//   - Packed payload structs whose $bits() is used as WIDTH at instantiation.
//   - ptr_w(): index width for a modulo-DEPTH pointer (at least 1 bit).
package ysyx_pipe_pkg;

  localparam int IFU_DATA_W = 64;
  localparam int IDU_DATA_W = 192;
  localparam int EXU_DATA_W = 109;
  localparam int LSU_DATA_W = 104;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifu_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [26:0] ctrl;
  } idu_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] st_data;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } exu_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [31:0] csr_data;
    logic [4:0]  rd;
    logic [2:0]  ctrl;
  } lsu_data_t;

  // A single-entry buffer still carries a 1-bit pointer that simply stays at 0.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: one valid/ready payload channel.
//   valid  producer -> consumer  payload valid
//   ready  consumer -> producer  consumer accepts this cycle
//   data   producer -> consumer  payload (WIDTH bits)
// master = producer side, slave = consumer side.
interface pipe_stage_buf_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_buf_ptr.sv
// pipe_buf_ptr: modulo-DEPTH pointer, wraps DEPTH-1 -> 0 for any DEPTH.
//   clk  in   clock
//   rst  in   asynchronous reset, active-low (ptr -> 0)
//   clr  in   synchronous clear, wins over inc
//   inc  in   advance by one
//   ptr  out  current index, ptr_w(DEPTH) bits
module pipe_buf_ptr
  import ysyx_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      ptr <= '0;
    else if (clr)  ptr <= '0;
    else if (inc)  ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: in-order inter-stage buffer of up to DEPTH payloads.
//   clk     in   clock
//   rst     in   asynchronous reset, active-low; drops all entries
//   flush   in   synchronous flush; voids this cycle's push and pop
//   in_if   slave  upstream valid/ready/data
//   out_if  master downstream valid/ready/data (data = head entry)
//   count   out  occupancy, $clog2(DEPTH+1) bits
// BYPASS=1 forwards in_data combinationally while empty; PIPE_READY=1 lets a
// full buffer accept when the head leaves in the same cycle.
module pipe_stage_buf
  import ysyx_pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter bit BYPASS     = 1'b0,
  parameter bit PIPE_READY = 1'b0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  pipe_stage_buf_if.slave         in_if,
  pipe_stage_buf_if.master        out_if,
  output logic [CW-1:0]           count
);

  localparam int            PW     = ptr_w(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  if (WIDTH < 1 || DEPTH < 1) begin : g_bad_param
    $error("pipe_stage_buf: WIDTH and DEPTH must both be >= 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic             empty, full, bypass_now;
  logic             push, pop, wr_en, rd_en;

  always_comb begin
    empty        = (cnt == '0);
    full         = (cnt == FULL_C);
    bypass_now   = BYPASS && empty;
    // Ready is deliberately not gated by flush; flush only voids the transfer.
    in_if.ready  = !full || (PIPE_READY && out_if.ready && full);
    out_if.valid = !flush && (!empty || (bypass_now && in_if.valid));
    out_if.data  = bypass_now ? in_if.data : mem[rd_ptr];
    push         = in_if.valid && in_if.ready && !flush;
    pop          = out_if.valid && out_if.ready;
    // A bypassed payload that is consumed immediately never touches storage.
    wr_en        = push && !(bypass_now && out_if.ready);
    rd_en        = pop && !empty;
  end

  assign count = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (flush)            cnt <= '0;
    else if (wr_en && !rd_en)  cnt <= cnt + CW'(1);
    else if (rd_en && !wr_en)  cnt <= cnt - CW'(1);
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_if.data;
  end

  pipe_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk), .rst (rst), .clr (flush), .inc (rd_en), .ptr (rd_ptr)
  );

  pipe_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk), .rst (rst), .clr (flush), .inc (wr_en), .ptr (wr_ptr)
  );

  // Occupancy must match the pointer distance; full and empty both give distance 0.
  logic cnt_ok;
  always_comb begin
    cnt_ok = (int'(cnt) <= DEPTH) &&
             (((int'(wr_ptr) - int'(rd_ptr) + DEPTH) % DEPTH) == (int'(cnt) % DEPTH));
  end

  a_cnt_ptr : assert property (@(posedge clk) disable iff (!rst) cnt_ok);

endmodule
